// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared constants and types for the instruction fetch queue.
//                IM_ADDR_BIT mirrors the core-wide instruction-memory word
//                address width. FQ_DEPTH is the default queue depth for
//                top-level use. The fq_op_e type names the per-cycle queue
//                operation that drives the occupancy update.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_queue_pkg;

    localparam int IM_ADDR_BIT = 12;
    localparam int FQ_DEPTH    = 4;
    localparam int FQ_INST_W   = 32;

    // Per-cycle queue operation. The encoding is {pop, push}, so fq_op()
    // packs the two handshake results directly.
    typedef enum logic [1:0] {
        FQ_OP_IDLE = 2'd0,
        FQ_OP_PUSH = 2'd1,
        FQ_OP_POP  = 2'd2,
        FQ_OP_BOTH = 2'd3
    } fq_op_e;

    function automatic fq_op_e fq_op(input logic push, input logic pop);
        return fq_op_e'({pop, push});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fq_entry_store.sv
`default_nettype none
// ============================================================================
//  Module      : fq_entry_store
//  Description : DEPTH x WIDTH register array holding fetch-queue entries.
//                It has one synchronous write port and one asynchronous read
//                port. The data registers have no reset. Validity is tracked
//                entirely by the control logic in fetch_queue.
//  Ports       : clk        rising-edge clock
//                wr_en_i    write strobe
//                wr_addr_i  slot to write
//                wr_data_i  packed entry to write
//                rd_addr_i  slot to read (combinational)
//                rd_data_o  packed entry at rd_addr_i
//  Revision    : 1.0  initial release
// ============================================================================
module fq_entry_store #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] slot_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            slot_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = slot_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch buffer between the PC/BHT stage and decode.
//                It captures {pc, pc_4, bht_hit, inst} once per accepted
//                fetch and presents the entries in order. The full output
//                back-pressures the PC stage. Asserting flush (a mispredict
//                redirect) discards every buffered entry.
//  Ports       : clk, rst        clock and synchronous active-high reset
//                en              global enable; 0 freezes all state
//                flush           discard all entries
//                in_*            fetch slot (valid, pc, pc_4, bht_hit, inst)
//                full            occupancy == DEPTH
//                out_ready       decode takes the head entry
//                out_valid       head entry present
//                out_*           head entry fields (zero when not valid)
//                count           occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int ADDR_W = IM_ADDR_BIT,
    parameter  int INST_W = FQ_INST_W,
    parameter  int DEPTH  = FQ_DEPTH,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_pc_4,
    input  logic              in_bht_hit,
    input  logic [INST_W-1:0] in_inst,
    output logic              full,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_4,
    output logic              out_bht_hit,
    output logic [INST_W-1:0] out_inst,
    output logic [CW-1:0]     count
);

    localparam int EW = 2 * ADDR_W + 1 + INST_W;

    // The pointers wrap by plain binary overflow, so the depth must be a
    // power of two.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("fetch_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          push;
    logic          pop;
    logic          store_we;
    logic [EW-1:0] store_wdata;
    logic [EW-1:0] store_rdata;

    // Status is decoded only from the registered count. This keeps full
    // independent of out_ready and avoids any combinational in->out path.
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = in_valid & ~full;
    assign pop  = out_valid & out_ready;

    // Writes are suppressed whenever the control state would not record
    // them. Otherwise a dropped push could overwrite a live slot.
    assign store_we    = en & ~rst & ~flush & push;
    assign store_wdata = {in_pc, in_pc_4, in_bht_hit, in_inst};

    fq_entry_store #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (store_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (store_wdata),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (store_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (en) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                unique case (fq_op(push, pop))
                    FQ_OP_PUSH: count_d = count_q + CW'(1);
                    FQ_OP_POP:  count_d = count_q - CW'(1);
                    default:    count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head data is masked when the queue is empty, so stale slot contents
    // never reach decode.
    always_comb begin
        out_pc      = '0;
        out_pc_4    = '0;
        out_bht_hit = 1'b0;
        out_inst    = '0;
        if (out_valid) begin
            {out_pc, out_pc_4, out_bht_hit, out_inst} = store_rdata;
        end
    end

    assign count = count_q;

    // Occupancy must match the pointer distance. When the queue is full,
    // the pointers have wrapped onto each other instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (count_q == CW'(DEPTH)) begin
                assert (wr_ptr_q == rd_ptr_q);
            end else begin
                assert (count_q == CW'(PW'(wr_ptr_q - rd_ptr_q)));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. It uses a directed
//                vector table, hand sequences, and randomized traffic. All
//                of these are checked against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int ADDR_W = 12;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic [ADDR_W-1:0] in_pc;
    logic [ADDR_W-1:0] in_pc_4;
    logic              in_bht_hit;
    logic [INST_W-1:0] in_inst;
    logic              full;
    logic              out_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_4;
    logic              out_bht_hit;
    logic [INST_W-1:0] out_inst;
    logic [CW-1:0]     count;

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_pc_4     (in_pc_4),
        .in_bht_hit  (in_bht_hit),
        .in_inst     (in_inst),
        .full        (full),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_pc_4    (out_pc_4),
        .out_bht_hit (out_bht_hit),
        .out_inst    (out_inst),
        .count       (count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: an ordered list of buffered fetches.
    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic              bht;
        logic [INST_W-1:0] inst;
    } ent_t;
    ent_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return 32'hA500_0000 | {20'h0, pc};
    endfunction

    task automatic drive(input logic r, input logic e, input logic f, input logic v,
                         input logic [ADDR_W-1:0] pc, input logic rdy);
        rst        = r;
        en         = e;
        flush      = f;
        in_valid   = v;
        in_pc      = pc;
        in_pc_4    = pc + 12'd1;
        in_bht_hit = pc[0];
        in_inst    = inst_of(pc);
        out_ready  = rdy;
    endtask

    task automatic model_step();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (rst) begin
            mq.delete();
        end else if (en) begin
            if (flush) begin
                mq.delete();
            end else begin
                do_pop  = (mq.size() > 0) && out_ready;
                do_push = in_valid && (mq.size() < DEPTH);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc = in_pc; e.pc4 = in_pc_4; e.bht = in_bht_hit; e.inst = in_inst;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic model_check();
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_full",  64'(full),  64'(mq.size() == DEPTH));
        chk("m_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_pc",   64'(out_pc),      64'(mq[0].pc));
            chk("m_pc4",  64'(out_pc_4),    64'(mq[0].pc4));
            chk("m_bht",  64'(out_bht_hit), 64'(mq[0].bht));
            chk("m_inst", 64'(out_inst),    64'(mq[0].inst));
        end else begin
            chk("m_zero", {out_pc, out_pc_4, out_bht_hit, out_inst[10:0]}, 64'd0);
        end
    endtask

    // The inputs must already be stable. The model advances on the same
    // edge as the DUT, and the outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic              r, e, f, v;
        logic [ADDR_W-1:0] pc;
        logic              rdy;
        logic [CW-1:0]     x_cnt;
        logic              x_valid, x_full;
        logic [ADDR_W-1:0] x_pc;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [ADDR_W-1:0] prev_pc;

        vt[0]  = '{0,1,0,1,12'h010,0, 3'd1,1,0,12'h010};
        vt[1]  = '{0,1,0,1,12'h011,0, 3'd2,1,0,12'h010};
        vt[2]  = '{0,1,0,1,12'h012,0, 3'd3,1,0,12'h010};
        vt[3]  = '{0,1,0,1,12'h013,0, 3'd4,1,1,12'h010};
        vt[4]  = '{0,1,0,1,12'h014,0, 3'd4,1,1,12'h010}; // dropped while full
        vt[5]  = '{0,0,1,1,12'h020,1, 3'd4,1,1,12'h010}; // enable freeze
        vt[6]  = '{0,0,1,1,12'h020,1, 3'd4,1,1,12'h010};
        vt[7]  = '{0,0,1,1,12'h020,1, 3'd4,1,1,12'h010};
        vt[8]  = '{0,1,0,1,12'h014,1, 3'd3,1,0,12'h011}; // full: pop only
        vt[9]  = '{0,1,0,1,12'h014,0, 3'd4,1,1,12'h011}; // push accepted
        vt[10] = '{0,1,0,0,12'h000,1, 3'd3,1,0,12'h012};
        vt[11] = '{0,1,1,1,12'h030,1, 3'd0,0,0,12'h000}; // flush wins
        vt[12] = '{0,1,0,1,12'h040,0, 3'd1,1,0,12'h040};
        vt[13] = '{0,1,0,0,12'h000,1, 3'd0,0,0,12'h000};
        vt[14] = '{0,1,0,1,12'h050,0, 3'd1,1,0,12'h050};
        vt[15] = '{0,1,0,1,12'h051,0, 3'd2,1,0,12'h050};
        vt[16] = '{0,1,0,1,12'h052,0, 3'd3,1,0,12'h050};
        vt[17] = '{1,1,0,1,12'h053,0, 3'd0,0,0,12'h000}; // reset mid-traffic
        vt[18] = '{1,1,0,1,12'h054,0, 3'd0,0,0,12'h000};
        vt[19] = '{0,1,0,0,12'h000,0, 3'd0,0,0,12'h000};

        drive(1, 1, 0, 0, 12'h0, 0);
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_full",  64'(full), 64'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].r, vt[i].e, vt[i].f, vt[i].v, vt[i].pc, vt[i].rdy);
            tick();
            chk($sformatf("vec%0d_count", i), 64'(count),     64'(vt[i].x_cnt));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].x_valid));
            chk($sformatf("vec%0d_full", i),  64'(full),      64'(vt[i].x_full));
            chk($sformatf("vec%0d_pc", i),    64'(out_pc),    64'(vt[i].x_pc));
        end

        // Streaming through several wraps: occupancy stays at one and the
        // head lags the input by exactly one cycle.
        prev_pc = 12'h0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(0, 1, 0, 1, 12'h100 + 12'(i), 1);
            tick();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(out_pc), 64'(12'h100 + 12'(i)));
            if (i > 0) chk("stream_lag", 64'(out_pc), 64'(prev_pc + 12'd1));
            prev_pc = out_pc;
        end
        drive(0, 1, 0, 0, 12'h0, 1);
        tick();
        chk("stream_drain", 64'(count), 64'd0);

        // Wrap order: fill, drain, fill again so the stored slots rotate.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drive(0, 1, 0, 1, 12'h200 + 12'(k * DEPTH + i), 0);
                tick();
            end
            for (int i = 0; i < DEPTH; i++) begin
                chk("wrap_pc", 64'(out_pc), 64'(12'h200 + 12'(k * DEPTH + i)));
                drive(0, 1, 0, 0, 12'h0, 1);
                tick();
            end
        end

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0),
                  1'($urandom),
                  12'($urandom),
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
